// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit packed-BCD adder, one decimal digit per clock,
// least-significant digit first, with a start/busy/done handshake.
// Optional build macro: BCD_CHECK_EN -- flags operand digits above 9 on err.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  ci,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   s,
  output logic                  co,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_a;
  logic [4*DIGITS-1:0]   r_b;
  logic [4*DIGITS-1:0]   r_s;
  logic [IW-1:0]         r_idx;
  logic                  r_carry;
  logic                  r_co;
  logic                  r_busy;
  logic                  r_done;

  logic [3:0]            w_a_dig;
  logic [3:0]            w_b_dig;
  logic [4:0]            w_t;
  logic [3:0]            w_digit;
  logic                  w_carry;
  logic                  w_last;

  // Select the current operand digits and apply the single-digit BCD add rule
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
    w_t = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0, r_carry};
    if (w_t > 5'd9) begin
      w_digit = w_t[3:0] + 4'd6;
      w_carry = 1'b1;
    end else begin
      w_digit = w_t[3:0];
      w_carry = 1'b0;
    end
    w_last = (r_idx == IW'(DIGITS - 1));
  end

  // Control FSM with registered handshake outputs, operand latches and sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= ci;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) r_s[4*i +: 4] <= w_digit;
          end
          r_carry <= w_carry;
          if (w_last) begin
            // Index wraps to 0 rather than reaching DIGITS
            r_idx   <= '0;
            r_co    <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_CHECK_EN
  logic r_err;
  logic w_bad;

  assign w_bad = (w_a_dig > 4'd9) || (w_b_dig > 4'd9);

  // Sticky invalid-digit flag, cleared when a new operation is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_err <= 1'b0;
    end else if (r_state == ADD && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): directed cases plus
// randomized operands against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        co;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: decimal value of a packed BCD word
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x /= 10;
    end
    return r;
  endfunction

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
    int sum = bcd2int(a) + bcd2int(b) + int'(c);
    return {(sum >= 10000) ? 1'b1 : 1'b0, int2bcd(sum % 10000)};
  endfunction

  // Full operation: handshake timing, result, result hold
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic eco, input logic eerr);
    int cyc = 0;
    int busy_cnt = 0;
    @(negedge clk);
    A = a; B = b; ci = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_latency", cyc, 4);
    check("busy_cycles", busy_cnt, 4);
    check("busy_at_done", busy, 0);
    check("sum", s, es);
    check("co", co, eco);
    check("err", err, eerr);
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("sum_hold", s, es);
  endtask

  task automatic op_model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] m = model(a, b, c);
    do_op(a, b, c, m[15:0], m[16], 1'b0);
  endtask

  initial begin : main
    logic [16:0] m;
    logic [15:0] ra, rb;
    int cyc, ndone, first, second;
    logic err_exp;

    rst_n = 1'b1; start = 1'b0; A = '0; B = '0; ci = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_co", co, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary sums
    do_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

    // Exhaustive single-digit sweep
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 10; a++)
        for (int b = 0; b < 10; b++)
          op_model(16'(a), 16'(b), 1'(c));

    // Random valid operands
    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      op_model(ra, rb, 1'($urandom_range(0, 1)));
    end

    // start and operand changes during ADD are ignored
    @(negedge clk);
    A = 16'h1234; B = 16'h5678; ci = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b1; A = 16'h9999; B = 16'h9999; ci = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("ign_latency", cyc, 4);
    check("ign_sum", s, 16'h6912);
    check("ign_co", co, 0);
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ign_no_second_done", ndone, 0);

    // Reset during the third ADD cycle
    @(negedge clk);
    A = 16'h5555; B = 16'h4444; ci = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_s", s, 0);
    check("midrst_co", co, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // start held high: one result per DIGITS+2 cycles
    @(negedge clk);
    A = 16'h0456; B = 16'h0789; ci = 1'b0; start = 1'b1;
    first = -1; second = -1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) begin
          first = e;
          check("b2b_sum", s, 16'h1245);
        end else if (second < 0) begin
          second = e;
        end
      end
    end
    start = 1'b0;
    check("b2b_first", first, 5);
    check("b2b_gap", second - first, 6);
    repeat (8) @(posedge clk);

    // Invalid digit: correction rule still applied, err only when checking is built
`ifdef BCD_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    do_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, err_exp);
    m = model(16'h0321, 16'h0123, 1'b0);
    do_op(16'h0321, 16'h0123, 1'b0, m[15:0], m[16], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
